branch_pc_controller: RTL

//  Multi-cycle sequencer for the sequential core: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/branch_pc_controller_pkg.sv | 26 ++
 rtl/branch_pc_controller_perf_counters.sv | 39 +++
 rtl/branch_pc_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/branch_pc_controller_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, reset instruction, widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package branch_pc_controller_pkg;

    // Default datapath / PC width
    localparam int CORE_XLEN = 64;

    // Instruction register contents after reset: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequencer state encoding, kept as plain constants so debug tools can decode the 3-bit bus
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    // A taken-branch target must be word aligned
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/branch_pc_controller_perf_counters.sv
// Retired-instruction and taken-branch counters, both wrapping silently.
// Latency: count visible the cycle after its increment strobe.
// Backpressure: none; strobes are single-cycle and always accepted.
module branch_pc_controller_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_instret,
    input  logic             inc_br_taken,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] br_taken_q;

    // Retire counter: one step per writeback, wraps at the top of its range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (inc_instret) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Taken-branch counter: one step per retiring taken branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_q <= '0;
        end else if (inc_br_taken) begin
            br_taken_q <= br_taken_q + CNT_W'(1);
        end
    end

    assign instret_cnt  = instret_q;
    assign br_taken_cnt = br_taken_q;

endmodule

// File: rtl/branch_pc_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning the PC, instr register and branch redirect.
// Latency: 4 cycles per non-memory instruction plus fetch wait; memory ops add 1 cycle plus dmem wait.
// Backpressure: waits indefinitely in FETCH for imem_ready and in MEM for dmem_done, holding its request.
module branch_pc_controller
    import branch_pc_controller_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    input  logic             branch,
    input  logic             mem_op,
    input  logic             take_branch,
    input  logic [XLEN-1:0]  branch_target,
    output logic             dmem_en,
    input  logic             dmem_done,
    output logic             reg_write_en,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    input  logic             halt_req,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next_q;
    logic [31:0]     instr_q;
    logic            br_taken_q;
    logic            is_branch_q;

    logic            take_br;
    logic            bad_target;
    logic            in_wb;

    assign take_br    = branch && take_branch;
    assign bad_target = is_misaligned(branch_target[1:0]);
    assign in_wb      = (state_q == S_WB);

    // Next-state selection; HALT and TRAP are absorbing until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // A misaligned redirect traps before any writeback, even if halt is pending
                if (take_br && bad_target) begin
                    state_d = S_TRAP;
                end else if (mem_op) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register; a reset mid-instruction simply abandons it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register captures the fetched word on the handshake cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
        end else if (state_q == S_FETCH && imem_ready) begin
            instr_q <= imem_rdata;
        end
    end

    // EXECUTE resolves the successor PC and remembers branch info for the WB strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next_q   <= RESET_PC;
            br_taken_q  <= 1'b0;
            is_branch_q <= 1'b0;
        end else if (state_q == S_EXECUTE) begin
            pc_next_q   <= take_br ? branch_target : (pc_q + XLEN'(4));
            br_taken_q  <= take_br;
            is_branch_q <= branch;
        end
    end

    // Architectural PC only moves at writeback, so a trap leaves it on the faulting branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (in_wb) begin
            pc_q <= pc_next_q;
        end
    end

    branch_pc_controller_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_instret  (in_wb),
        .inc_br_taken (in_wb && br_taken_q),
        .instret_cnt  (instret_cnt),
        .br_taken_cnt (br_taken_cnt)
    );

    // All strobes decode from registered state only, so no input-to-output paths exist
    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign dmem_en      = (state_q == S_MEM);
    assign reg_write_en = in_wb && !is_branch_q;
    assign halted       = (state_q == S_HALT);
    assign trap         = (state_q == S_TRAP);
    assign instr        = instr_q;
    assign pc           = pc_q;
    assign state        = state_q;

endmodule
